// File: rtl/full_subtractor_if.sv
// rtl/full_subtractor_if.sv - operand/result bundle for the registered full subtractor
interface full_subtractor_if #(
    parameter int WIDTH = 1
);
    logic             Valid_In;
    logic [WIDTH-1:0] Data_A_In;
    logic [WIDTH-1:0] Data_B_In;
    logic             Borrow_In;
    logic [WIDTH-1:0] Sum_Out;
    logic             Borrow_Out;
    logic             Valid_Out;

    modport master (
        output Valid_In,
        output Data_A_In,
        output Data_B_In,
        output Borrow_In,
        input  Sum_Out,
        input  Borrow_Out,
        input  Valid_Out
    );

    modport slave (
        input  Valid_In,
        input  Data_A_In,
        input  Data_B_In,
        input  Borrow_In,
        output Sum_Out,
        output Borrow_Out,
        output Valid_Out
    );
endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - registered WIDTH-bit ripple-borrow subtractor (A - B - Borrow_In)
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic              Clock_In,
    input  logic              Reset_N_In,
    full_subtractor_if.slave  bus
);
    logic [WIDTH:0]   borrow_chain;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sum_q;
    logic             borrow_q;
    logic             valid_q;

    assign borrow_chain[0] = bus.Borrow_In;

    // One full-subtractor cell per bit; borrow ripples from LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic a_bit;
        logic b_bit;
        logic c_bit;

        assign a_bit = bus.Data_A_In[i];
        assign b_bit = bus.Data_B_In[i];
        assign c_bit = borrow_chain[i];

        assign diff[i]           = a_bit ^ b_bit ^ c_bit;
        assign borrow_chain[i+1] = (~a_bit & b_bit) | (~a_bit & c_bit) | (b_bit & c_bit);
    end

    // Result registers only load on a valid beat, so unknown operands on idle
    // cycles never reach the held outputs.
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            sum_q    <= '0;
            borrow_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.Valid_In;
            if (bus.Valid_In) begin
                sum_q    <= diff;
                borrow_q <= borrow_chain[WIDTH];
            end
        end
    end

    assign bus.Sum_Out    = sum_q;
    assign bus.Borrow_Out = borrow_q;
    assign bus.Valid_Out  = valid_q;
endmodule

// File: tb/tb_full_subtractor.sv
// tb/tb_full_subtractor.sv - scoreboard bench for full_subtractor at WIDTH 1, 4 and 8
module tb_full_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    full_subtractor_if #(.WIDTH(1)) b1 ();
    full_subtractor_if #(.WIDTH(4)) b4 ();
    full_subtractor_if #(.WIDTH(8)) b8 ();

    full_subtractor #(.WIDTH(1)) u1 (.Clock_In(clk), .Reset_N_In(rst_n), .bus(b1));
    full_subtractor #(.WIDTH(4)) u4 (.Clock_In(clk), .Reset_N_In(rst_n), .bus(b4));
    full_subtractor #(.WIDTH(8)) u8 (.Clock_In(clk), .Reset_N_In(rst_n), .bus(b8));

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] q1[$];
    logic [4:0] q4[$];
    logic [8:0] q8[$];
    logic       pend1, pend4, pend8;
    logic [1:0] held1;
    logic [4:0] held4;
    logic [8:0] held8;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic bin);
        logic [1:0] r;
        b1.Valid_In = v; b1.Data_A_In = a; b1.Data_B_In = b; b1.Borrow_In = bin;
        pend1 = v;
        r = {1'b0, a} - {1'b0, b} - {1'b0, bin};
        if (v) q1.push_back(r);
    endtask

    task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic bin);
        logic [4:0] r;
        b4.Valid_In = v; b4.Data_A_In = a; b4.Data_B_In = b; b4.Borrow_In = bin;
        pend4 = v;
        r = {1'b0, a} - {1'b0, b} - {4'b0, bin};
        if (v) q4.push_back(r);
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [8:0] r;
        b8.Valid_In = v; b8.Data_A_In = a; b8.Data_B_In = b; b8.Borrow_In = bin;
        pend8 = v;
        r = {1'b0, a} - {1'b0, b} - {8'b0, bin};
        if (v) q8.push_back(r);
    endtask

    task automatic idle_all();
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive4(1'b0, 4'h0, 4'h0, 1'b0);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("valid1", b1.Valid_Out, pend1);
        if (pend1) begin
            if (q1.size() == 0) chk("sb1_empty", 64'd1, 64'd0);
            else held1 = q1.pop_front();
        end
        chk("res1", {b1.Borrow_Out, b1.Sum_Out}, held1);
        chk("valid4", b4.Valid_Out, pend4);
        if (pend4) begin
            if (q4.size() == 0) chk("sb4_empty", 64'd1, 64'd0);
            else held4 = q4.pop_front();
        end
        chk("res4", {b4.Borrow_Out, b4.Sum_Out}, held4);
        chk("valid8", b8.Valid_Out, pend8);
        if (pend8) begin
            if (q8.size() == 0) chk("sb8_empty", 64'd1, 64'd0);
            else held8 = q8.pop_front();
        end
        chk("res8", {b8.Borrow_Out, b8.Sum_Out}, held8);
        idle_all();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sum1"}, b1.Sum_Out, 64'd0);
        chk({tag, "_bo1"}, b1.Borrow_Out, 64'd0);
        chk({tag, "_v1"}, b1.Valid_Out, 64'd0);
        chk({tag, "_sum4"}, b4.Sum_Out, 64'd0);
        chk({tag, "_bo4"}, b4.Borrow_Out, 64'd0);
        chk({tag, "_v4"}, b4.Valid_Out, 64'd0);
        chk({tag, "_sum8"}, b8.Sum_Out, 64'd0);
        chk({tag, "_bo8"}, b8.Borrow_Out, 64'd0);
        chk({tag, "_v8"}, b8.Valid_Out, 64'd0);
    endtask

    initial begin
        logic [1:0] tt[8];
        logic [2:0] tv;
        tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        held1 = '0; held4 = '0; held8 = '0;
        rst_n = 1'b0;
        idle_all();
        #12;
        chk_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth table, constants in (D,Bout) order
        for (int i = 0; i < 8; i++) begin
            tv = i[2:0];
            drive1(1'b1, tv[2], tv[1], tv[0]);
            tick();
            chk("tt", {b1.Sum_Out, b1.Borrow_Out}, tt[i]);
        end

        // hold with opposing operands on idle cycles, X operands on WIDTH=8
        drive1(1'b1, 1'b1, 1'b0, 1'b0);
        drive8(1'b1, 8'hA5, 8'h3C, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive1(1'b0, 1'b0, 1'b1, 1'b1);
            drive8(1'b0, 8'bx, 8'bx, 1'bx);
            b8.Valid_In = 1'b0;
            tick();
            chk("hold_d", {b1.Sum_Out, b1.Borrow_Out}, 2'b10);
            chk("hold8", {b8.Borrow_Out, b8.Sum_Out}, 9'h068);
        end

        // WIDTH=4 wrap/borrow, back to back
        drive4(1'b1, 4'd3, 4'd5, 1'b1); tick(); chk("w4_a", {b4.Borrow_Out, b4.Sum_Out}, 5'h1D);
        drive4(1'b1, 4'd9, 4'd4, 1'b1); tick(); chk("w4_b", {b4.Borrow_Out, b4.Sum_Out}, 5'h04);
        drive4(1'b1, 4'd0, 4'd0, 1'b1); tick(); chk("w4_c", {b4.Borrow_Out, b4.Sum_Out}, 5'h1F);

        // WIDTH=8 boundaries
        drive8(1'b1, 8'h5A, 8'h5A, 1'b0); tick(); chk("w8_eq", {b8.Borrow_Out, b8.Sum_Out}, 9'h000);
        drive8(1'b1, 8'h00, 8'h00, 1'b1); tick(); chk("w8_wrap", {b8.Borrow_Out, b8.Sum_Out}, 9'h1FF);
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1); tick(); chk("w8_ones", {b8.Borrow_Out, b8.Sum_Out}, 9'h1FF);

        // random soak, random Valid_In
        for (int i = 0; i < 24; i++) begin
            drive1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            drive8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)));
            tick();
        end

        // asynchronous reset mid-cycle with nonzero outputs and valid operands pending
        drive1(1'b1, 1'b0, 1'b1, 1'b0);
        drive4(1'b1, 4'd2, 4'd7, 1'b0);
        drive8(1'b1, 8'h10, 8'h80, 1'b1);
        tick();
        drive1(1'b1, 1'b1, 1'b0, 1'b0);
        drive4(1'b1, 4'd8, 4'd1, 1'b0);
        drive8(1'b1, 8'h77, 8'h11, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("arst");
        q1.delete(); q4.delete(); q8.delete();
        held1 = '0; held4 = '0; held8 = '0;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst_hold");
        #1 rst_n = 1'b1;
        #1 chk("post_rst_v8", b8.Valid_Out, 64'd0);
        drive1(1'b1, 1'b1, 1'b0, 1'b0);
        drive4(1'b1, 4'd8, 4'd1, 1'b0);
        drive8(1'b1, 8'h77, 8'h11, 1'b0);
        tick();
        chk("post_rst_ld8", {b8.Borrow_Out, b8.Sum_Out}, 9'h066);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
